deser_framer: RTL
=================

Name: deser_framer

Overview:
- Downstream stage of the serial-to-parallel deserializer.
- Consumes the deserializer's free-running parallel shift word, which takes one new bit per clock. Hunts for a sync word, confirms alignment and tracks frames.
- Emits aligned payload words with a one-cycle valid strobe, plus start/end-of-frame markers.
- Feeds the packet/buffer logic that needs word-aligned data.

Parameters:
- DATA_WIDTH, 16, width of the shift word and the output word (>=4).
- SYNC_WORD, 16'hA5C3, alignment pattern; DATA_WIDTH bits wide.
- FRAME_WORDS, 8, payload words between consecutive sync words (>=1).
- MISS_LIMIT, 3, consecutive missed sync slots in LOCKED before returning to HUNT (>=1).

Ports:
- clk, input, 1, rising-edge clock; the deserializer shifts in one bit per clk.
- resetn, input, 1, asynchronous active-low reset.
- shift_word, input, DATA_WIDTH, registered parallel output of the deserializer; newest bit in the LSB.
- dout_word, output, DATA_WIDTH, aligned payload word; holds its value between strobes.
- word_valid, output, 1, one-cycle strobe: dout_word is a new payload word.
- sof, output, 1, asserted with word_valid on payload word index 0.
- eof, output, 1, asserted with word_valid on payload word index FRAME_WORDS-1.
- locked, output, 1, high in LOCKED.
- sync_err, output, 1, one-cycle pulse on a sync-slot mismatch in VERIFY or LOCKED.
- lock_loss_cnt, output, 8, count of LOCKED->HUNT transitions (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low and takes effect immediately, including mid-frame. While in reset:
  - state=HUNT; bit_cnt, word_idx and miss_cnt = 0.
  - dout_word=0; word_valid, sof, eof, locked, sync_err = 0.
  - lock_loss_cnt=0.
- Internal state:
  - bit_cnt counts 0..DATA_WIDTH-1 (width $clog2(DATA_WIDTH)).
  - word_idx counts 0..FRAME_WORDS; FRAME_WORDS is the sync slot.
  - miss_cnt counts 0..MISS_LIMIT.
- Boundary cycle: a cycle with bit_cnt==DATA_WIDTH-1 while in VERIFY or LOCKED. On a boundary cycle shift_word holds exactly one complete new word.
- HUNT:
  - Every cycle, if shift_word==SYNC_WORD, the next edge sets state=VERIFY, bit_cnt=0, word_idx=0.
  - No output strobes in HUNT.
- VERIFY and LOCKED, every cycle: bit_cnt increments and wraps to 0 after a boundary cycle.
- Boundary cycle with word_idx<FRAME_WORDS:
  - In LOCKED, the next edge registers dout_word=shift_word and word_valid=1, plus sof (word_idx==0) and eof (word_idx==FRAME_WORDS-1).
  - In VERIFY, the word is discarded.
  - In both states, word_idx increments.
- Boundary cycle with word_idx==FRAME_WORDS (sync slot); word_idx returns to 0 in every case.
  - VERIFY, match: state->LOCKED, miss_cnt=0.
  - VERIFY, mismatch: sync_err pulse, state->HUNT. Hunting resumes the cycle after; no same-cycle rematch.
  - LOCKED, match: miss_cnt=0.
  - LOCKED, mismatch: sync_err pulse, miss_cnt+1. If miss_cnt reaches MISS_LIMIT: state->HUNT and lock_loss_cnt increments. Otherwise stay LOCKED (flywheel) and keep emitting payload.
- Output registers:
  - Latency: the last bit of a payload word is in shift_word on cycle T; dout_word and word_valid are visible in cycle T+1.
  - word_valid, sof, eof and sync_err are single-cycle pulses; word_valid spacing is exactly DATA_WIDTH cycles.
  - locked is registered from the state: high the cycle after entry to LOCKED, low the cycle after exit.
- Payload words equal to SYNC_WORD are treated as data; no resync while LOCKED.

Optional Feature:
- Macro: DESER_FRAMER_STATS_EN.
- Defined: lock_loss_cnt increments on each LOCKED->HUNT transition and saturates at 8'hFF.
- Undefined: the counter logic is removed and lock_loss_cnt is tied to 8'h00. Port list is unchanged.

Decomposition:
- Package deser_framer_pkg:
  - framer_state_e enum {HUNT, VERIFY, LOCKED}, 2 bits.
  - Localparam helpers for counter widths.
- Sub-module deser_slot_ctr: the bit_cnt/word_idx pair, with clear and enable inputs and outputs boundary and sync_slot.
- The top level holds the FSM, miss_cnt, output registers and the stats counter.

Test Plan:
- Idle data, then SYNC_WORD, FRAME_WORDS payload words and a second SYNC_WORD, with defaults (payload 16'h0001..16'h0008):
  - locked rises 1 cycle after the second sync's boundary.
  - The second frame's 8 words are emitted with sof on 16'h0001 and eof on 16'h0008, 16 cycles apart.
- Reach LOCKED, then corrupt one sync slot (16'hA5C2):
  - One sync_err pulse; locked stays 1 and payload continues.
  - The next good sync clears miss_cnt.
- Reach LOCKED, then corrupt 3 consecutive sync slots:
  - 3 sync_err pulses and locked falls after the third.
  - lock_loss_cnt=1 with the macro, 0 without.
- SYNC_WORD followed by a bad sync slot while in VERIFY:
  - sync_err pulse, return to HUNT, no word_valid ever asserted.
- Deassert resetn mid-frame while LOCKED, then reassert:
  - All outputs go to 0 immediately (asynchronously).
  - The block relocks after sync, verify and sync sequence.
- Payload word equal to 16'hA5C3 while LOCKED:
  - Emitted as data with word_valid; alignment unchanged.

Source files
------------

// File: rtl/deser_framer_pkg.sv
// Shared types and width helpers for the deserializer framer.
package deser_framer_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } framer_state_e;

    localparam int STATS_W = 8;
    localparam logic [STATS_W-1:0] STATS_MAX = 8'hFF;

    // Bits needed to hold a counter running 0..max_val (never less than one).
    function automatic int cnt_w(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/deser_slot_ctr.sv
// Bit/word position tracker: marks word boundaries and the sync slot of a frame.
module deser_slot_ctr
    import deser_framer_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAME_WORDS = 8
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             clear,
    input  logic                             enable,
    output logic [cnt_w(FRAME_WORDS)-1:0]    word_idx,
    output logic                             boundary,
    output logic                             sync_slot
);

    localparam int BIT_W = cnt_w(DATA_WIDTH - 1);
    localparam int IDX_W = cnt_w(FRAME_WORDS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] SYNC_IDX  = IDX_W'(FRAME_WORDS);

    logic [BIT_W-1:0] bit_cnt;

    assign boundary  = enable && (bit_cnt == LAST_BIT);
    assign sync_slot = (word_idx == SYNC_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt  <= '0;
            word_idx <= '0;
        end else if (clear) begin
            bit_cnt  <= '0;
            word_idx <= '0;
        end else if (enable) begin
            if (bit_cnt == LAST_BIT) begin
                bit_cnt  <= '0;
                word_idx <= sync_slot ? '0 : word_idx + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deser_framer.sv
// Frame aligner behind the serial deserializer: hunt, verify and track sync words.
// Build option DESER_FRAMER_STATS_EN enables the saturating lock-loss counter.
//
// state  | meaning
// HUNT   | compare every cycle's shift word against the sync pattern
// VERIFY | aligned on a candidate sync, waiting for the next sync slot to confirm
// LOCKED | emitting payload words; tolerates up to MISS_LIMIT-1 missed syncs
module deser_framer
    import deser_framer_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 16'hA5C3,
    parameter int                    FRAME_WORDS = 8,
    parameter int                    MISS_LIMIT  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] shift_word,
    output logic [DATA_WIDTH-1:0] dout_word,
    output logic                  word_valid,
    output logic                  sof,
    output logic                  eof,
    output logic                  locked,
    output logic                  sync_err,
    output logic [STATS_W-1:0]    lock_loss_cnt
);

    localparam int IDX_W  = cnt_w(FRAME_WORDS);
    localparam int MISS_W = cnt_w(MISS_LIMIT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

    framer_state_e      state_q, state_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [IDX_W-1:0]   word_idx;
    logic               boundary, sync_slot;
    logic               sync_match;
    logic               emit, err_d, loss_evt;

    assign sync_match = (shift_word == SYNC_WORD);

    deser_slot_ctr #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_slot_ctr (
        .clk       (clk),
        .resetn    (resetn),
        .clear     ((state_q == HUNT) && sync_match),
        .enable    (state_q != HUNT),
        .word_idx  (word_idx),
        .boundary  (boundary),
        .sync_slot (sync_slot)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        emit     = 1'b0;
        err_d    = 1'b0;
        loss_evt = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (sync_match) begin
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary && sync_slot) begin
                    if (sync_match) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary && sync_slot) begin
                    if (sync_match) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        // Flywheel through isolated misses; only a full run drops lock.
                        if (miss_q >= MISS_LAST) begin
                            miss_d   = MISS_MAX;
                            state_d  = HUNT;
                            loss_evt = 1'b1;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end else if (boundary) begin
                    emit = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            miss_q     <= '0;
            dout_word  <= '0;
            word_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            miss_q     <= miss_d;
            word_valid <= emit;
            sof        <= emit && (word_idx == '0);
            eof        <= emit && (word_idx == LAST_IDX);
            sync_err   <= err_d;
            locked     <= (state_d == LOCKED);
            if (emit) begin
                dout_word <= shift_word;
            end
        end
    end

`ifdef DESER_FRAMER_STATS_EN
    logic [STATS_W-1:0] loss_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != STATS_MAX)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    logic unused_stats;
    assign unused_stats  = loss_evt;
    assign lock_loss_cnt = '0;
`endif

endmodule
